// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes,
// ALU operation codes and the PC / writeback mux selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] PC_JALR   = 2'd3;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from opcode / funct3 / funct7[5].
// Purely combinational, zero latency; no handshake, so no backpressure.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [4:0] alu_ctrl
);

    logic [4:0] rtype_op;

    always_comb begin
        rtype_op = ALU_ADD;
        case (funct3)
            3'd0: rtype_op = ALU_ADD;
            3'd1: rtype_op = ALU_SLL;
            3'd2: rtype_op = ALU_SLT;
            3'd3: rtype_op = ALU_SLTU;
            3'd4: rtype_op = ALU_XOR;
            3'd5: rtype_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'd6: rtype_op = ALU_OR;
            3'd7: rtype_op = ALU_AND;
            default: rtype_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (opcode)
            OPC_OP:     alu_ctrl = (funct3 == 3'd0 && funct7_b5) ? ALU_SUB : rtype_op;
            // immediates occupy funct7, so bit 30 only selects SRAI on the shift-right slot
            OPC_OP_IMM: alu_ctrl = rtype_op;
            OPC_LUI:    alu_ctrl = ALU_PASSB;
            OPC_BRANCH: alu_ctrl = ALU_SUB;
            default:    alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// RV32I multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEM/WB); outputs are combinational from state and IR.
// Latency: ALU/jump 4, load 5, store 4, branch 3 cycles; FETCH and MEM stall until imem_ready / dmem_ready.
// Build option CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP instead of executing as a NOP.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_code,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        Branch,
    output logic [1:0]  PCSrc,
    output logic [4:0]  ALUControl,
    output logic [1:0]  WBSel,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        illegal
);

    localparam state_t RST_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] dec_alu;
    logic       unused_instr_bits;

    assign opcode            = instruction_code[6:0];
    assign rd                = instruction_code[11:7];
    assign unused_instr_bits = ^{instruction_code[31], instruction_code[29:15]};

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .funct3    (instruction_code[14:12]),
        .funct7_b5 (instruction_code[30]),
        .alu_ctrl  (dec_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        PCSrc      = PC_PLUS4;
        ALUControl = ALU_ADD;
        WBSel      = WB_ALU;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: state_d = S_EXECUTE;

            S_EXECUTE: begin
                case (opcode)
                    OPC_OP: begin
                        ALUControl = dec_alu;
                        state_d    = S_WB;
                    end
                    OPC_OP_IMM, OPC_LUI, OPC_JAL, OPC_JALR: begin
                        ALUSrc     = 1'b1;
                        ALUControl = dec_alu;
                        state_d    = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        ALUSrc     = 1'b1;
                        ALUControl = dec_alu;
                        state_d    = S_MEM;
                    end
                    OPC_BRANCH: begin
                        Branch     = 1'b1;
                        ALUControl = dec_alu;
                        pc_we      = 1'b1;
                        PCSrc      = branch_taken ? PC_BRANCH : PC_PLUS4;
                        state_d    = S_FETCH;
                    end
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        illegal = 1'b1;
                        state_d = S_TRAP;
`else
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end

            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (opcode == OPC_STORE);
                ALUSrc     = 1'b1;
                ALUControl = ALU_ADD;
                if (dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                RegWrite   = (rd != 5'd0);
                ALUSrc     = (opcode != OPC_OP);
                ALUControl = dec_alu;
                pc_we      = 1'b1;
                case (opcode)
                    OPC_JAL:  begin PCSrc = PC_JAL;  WBSel = WB_PC4; end
                    OPC_JALR: begin PCSrc = PC_JALR; WBSel = WB_PC4; end
                    OPC_LOAD: WBSel = WB_MEM;
                    default:  WBSel = WB_ALU;
                endcase
                state_d = S_FETCH;
            end

            S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`else
                state_d = S_FETCH;
`endif
            end

            default: state_d = S_FETCH;
        endcase

        // reset abandons the instruction immediately, before the async flop clears
        if (rst) begin
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            ALUSrc     = 1'b0;
            RegWrite   = 1'b0;
            Branch     = 1'b0;
            PCSrc      = PC_PLUS4;
            ALUControl = ALU_ADD;
            WBSel      = WB_ALU;
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller: one record per clock cycle,
// plus hand-written sequences for the illegal opcode and a reset pulse mid-MEM.
module tb_multicycle_controller;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       alu_src;
        logic       reg_write;
        logic       branch;
        logic [1:0] pc_src;
        logic [4:0] alu_ctl;
        logic [1:0] wb_sel;
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        logic        imr;
        logic        dmr;
        outs_t       exp;
        string       nm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction_code = 32'h0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        ir_we, pc_we, ALUSrc, RegWrite, Branch;
    logic [1:0]  PCSrc, WBSel;
    logic [4:0]  ALUControl;
    logic        imem_req, dmem_req, dmem_we, illegal;

    int checks = 0;
    int errors = 0;

    vec_t  vecs[$];
    outs_t ZERO, F_HIT, F_WAIT;

    multicycle_controller dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_code (instruction_code),
        .branch_taken     (branch_taken),
        .imem_ready       (imem_ready),
        .dmem_ready       (dmem_ready),
        .ir_we            (ir_we),
        .pc_we            (pc_we),
        .ALUSrc           (ALUSrc),
        .RegWrite         (RegWrite),
        .Branch           (Branch),
        .PCSrc            (PCSrc),
        .ALUControl       (ALUControl),
        .WBSel            (WBSel),
        .imem_req         (imem_req),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .illegal          (illegal)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(logic irw, logic pcw, logic asrc, logic rw, logic br,
                                logic [1:0] pcs, logic [4:0] ctl, logic [1:0] wbs,
                                logic im, logic dm, logic dwe, logic ill);
        return {irw, pcw, asrc, rw, br, pcs, ctl, wbs, im, dm, dwe, ill};
    endfunction

    function automatic outs_t actual();
        return {ir_we, pc_we, ALUSrc, RegWrite, Branch, PCSrc, ALUControl, WBSel,
                imem_req, dmem_req, dmem_we, illegal};
    endfunction

    task automatic check(input string nm, input outs_t exp);
        outs_t act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (irw pcw asrc rw br pcs ctl wbs im dm dwe ill)",
                     nm, act, exp);
        end
    endtask

    // drive one cycle's inputs in the low phase, check outputs, then let the posedge happen
    task automatic step(input vec_t v);
        instruction_code = v.instr;
        branch_taken     = v.bt;
        imem_ready       = v.imr;
        dmem_ready       = v.dmr;
        #1;
        check(v.nm, v.exp);
        @(negedge clk);
    endtask

    function automatic void add(logic [31:0] i, logic bt, logic imr, logic dmr, outs_t e, string nm);
        vec_t v;
        v.instr = i; v.bt = bt; v.imr = imr; v.dmr = dmr; v.exp = e; v.nm = nm;
        vecs.push_back(v);
    endfunction

    // FETCH (ready at once), DECODE, EXECUTE, WB
    function automatic void seq4(logic [31:0] i, outs_t e_ex, outs_t e_wb, string nm);
        add(i, 1'b0, 1'b1, 1'b0, F_HIT, {nm, "_fetch"});
        add(i, 1'b0, 1'b0, 1'b0, ZERO,  {nm, "_decode"});
        add(i, 1'b0, 1'b0, 1'b0, e_ex,  {nm, "_exec"});
        add(i, 1'b0, 1'b0, 1'b0, e_wb,  {nm, "_wb"});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ZERO   = o(0,0,0,0,0,2'd0,5'd0,2'd0,0,0,0,0);
        F_HIT  = o(1,0,0,0,0,2'd0,5'd0,2'd0,1,0,0,0);
        F_WAIT = o(0,0,0,0,0,2'd0,5'd0,2'd0,1,0,0,0);

        // addi x1,x0,5 with stray ready pulses in DECODE/EXECUTE that must be ignored
        add(32'h00500093, 0, 1, 0, F_HIT, "addi_fetch");
        add(32'h00500093, 0, 1, 0, ZERO, "addi_decode_imr_ignored");
        add(32'h00500093, 0, 0, 1, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0), "addi_exec_dmr_ignored");
        add(32'h00500093, 0, 0, 0, o(0,1,1,1,0,2'd0,5'd0,2'd0,0,0,0,0), "addi_wb");
        // beq taken, with one fetch stall
        add(32'h00000463, 1, 0, 0, F_WAIT, "beq_t_fetch_wait");
        add(32'h00000463, 1, 1, 0, F_HIT, "beq_t_fetch");
        add(32'h00000463, 1, 0, 0, ZERO, "beq_t_decode");
        add(32'h00000463, 1, 0, 0, o(0,1,0,0,1,2'd1,5'd1,2'd0,0,0,0,0), "beq_t_exec");
        // beq not taken
        add(32'h00000463, 0, 1, 0, F_HIT, "beq_nt_fetch");
        add(32'h00000463, 0, 0, 0, ZERO, "beq_nt_decode");
        add(32'h00000463, 0, 0, 0, o(0,1,0,0,1,2'd0,5'd1,2'd0,0,0,0,0), "beq_nt_exec");
        // jumps
        seq4(32'h010000EF, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd2,5'd0,2'd2,0,0,0,0), "jal");
        seq4(32'h000100E7, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd3,5'd0,2'd2,0,0,0,0), "jalr");
        // sw x2,4(x1), one MEM wait cycle
        add(32'h0020A223, 0, 1, 0, F_HIT, "sw_fetch");
        add(32'h0020A223, 0, 0, 0, ZERO, "sw_decode");
        add(32'h0020A223, 0, 0, 0, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0), "sw_exec");
        add(32'h0020A223, 0, 0, 0, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,1,1,0), "sw_mem_wait");
        add(32'h0020A223, 0, 0, 1, o(0,1,1,0,0,2'd0,5'd0,2'd0,0,1,1,0), "sw_mem_done");
        // lw x2,0(x1), dmem_ready delayed 3 cycles: 8 cycles total
        add(32'h0000A103, 0, 1, 0, F_HIT, "lw_fetch");
        add(32'h0000A103, 0, 0, 0, ZERO, "lw_decode");
        add(32'h0000A103, 0, 0, 0, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0), "lw_exec");
        for (int k = 0; k < 3; k++)
            add(32'h0000A103, 0, 0, 0, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,1,0,0), "lw_mem_wait");
        add(32'h0000A103, 0, 0, 1, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,1,0,0), "lw_mem_done");
        add(32'h0000A103, 0, 0, 0, o(0,1,1,1,0,2'd0,5'd0,2'd1,0,0,0,0), "lw_wb");
        // ALU decode coverage
        seq4(32'h002081B3, o(0,0,0,0,0,2'd0,5'd0,2'd0,0,0,0,0),
                           o(0,1,0,1,0,2'd0,5'd0,2'd0,0,0,0,0), "add");
        seq4(32'h402081B3, o(0,0,0,0,0,2'd0,5'd1,2'd0,0,0,0,0),
                           o(0,1,0,1,0,2'd0,5'd1,2'd0,0,0,0,0), "sub");
        seq4(32'h0020E1B3, o(0,0,0,0,0,2'd0,5'd8,2'd0,0,0,0,0),
                           o(0,1,0,1,0,2'd0,5'd8,2'd0,0,0,0,0), "or");
        seq4(32'h0020B1B3, o(0,0,0,0,0,2'd0,5'd4,2'd0,0,0,0,0),
                           o(0,1,0,1,0,2'd0,5'd4,2'd0,0,0,0,0), "sltu");
        seq4(32'h4030D293, o(0,0,1,0,0,2'd0,5'd7,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd0,5'd7,2'd0,0,0,0,0), "srai");
        seq4(32'h0030D293, o(0,0,1,0,0,2'd0,5'd6,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd0,5'd6,2'd0,0,0,0,0), "srli");
        seq4(32'h40000093, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd0,5'd0,2'd0,0,0,0,0), "addi_bit30");
        seq4(32'h12345237, o(0,0,1,0,0,2'd0,5'd10,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd0,5'd10,2'd0,0,0,0,0), "lui");
        seq4(32'h00000013, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0),
                           o(0,1,1,0,0,2'd0,5'd0,2'd0,0,0,0,0), "nop_rd0");

        // reset state: outputs forced low even with imem_ready high
        rst = 1'b1;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", ZERO);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // illegal opcode 0x00000000
        step('{32'h0, 1'b0, 1'b1, 1'b0, F_HIT, "ill_fetch"});
        step('{32'h0, 1'b0, 1'b0, 1'b0, ZERO, "ill_decode"});
`ifdef CTRL_ILLEGAL_TRAP_EN
        step('{32'h0, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,2'd0,5'd0,2'd0,0,0,0,1), "ill_exec_trap"});
        step('{32'h0, 1'b0, 1'b1, 1'b0, o(0,0,0,0,0,2'd0,5'd0,2'd0,0,0,0,1), "ill_trap_hold1"});
        step('{32'h00500093, 1'b0, 1'b1, 1'b1, o(0,0,0,0,0,2'd0,5'd0,2'd0,0,0,0,1), "ill_trap_hold2"});
        rst = 1'b1;
        #1;
        check("trap_reset_outputs", ZERO);
        @(negedge clk);
        rst = 1'b0;
`else
        step('{32'h0, 1'b0, 1'b0, 1'b0, o(0,1,0,0,0,2'd0,5'd0,2'd0,0,0,0,0), "ill_exec_nop"});
        step('{32'h0, 1'b0, 1'b0, 1'b0, F_WAIT, "ill_next_fetch"});
`endif

        // lw into MEM, then an asynchronous reset pulse mid-MEM
        step('{32'h0000A103, 1'b0, 1'b1, 1'b0, F_HIT, "rstmem_fetch"});
        step('{32'h0000A103, 1'b0, 1'b0, 1'b0, ZERO, "rstmem_decode"});
        step('{32'h0000A103, 1'b0, 1'b0, 1'b0, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0), "rstmem_exec"});
        instruction_code = 32'h0000A103;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("rstmem_in_mem", o(0,0,1,0,0,2'd0,5'd0,2'd0,0,1,0,0));
        #2;
        rst = 1'b1;
        #1;
        check("rstmem_outputs_zero_now", ZERO);
        dmem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rstmem_outputs_zero_held", ZERO);
        @(negedge clk);
        rst = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("rstmem_restart_fetch", F_WAIT);
        @(negedge clk);
        seq4(32'h00500093, o(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0),
                           o(0,1,1,1,0,2'd0,5'd0,2'd0,0,0,0,0), "post_rst_addi");
        for (int i = vecs.size() - 4; i < vecs.size(); i++) step(vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
